// File: rtl/mem_req_ctrl.sv
// Host-side request controller for a synchronous memory: forwards requests to the
// memory control unit, tracks reads in flight and buffers read data in a response FIFO.
module mem_req_ctrl #(
  parameter int ADDR_BIT_COUNT = 11,
  parameter int WORD_SIZE      = 32,
  parameter int RD_LAT         = 1,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_WE,
  input  logic [ADDR_BIT_COUNT-1:0] REQ_ADDR,
  input  logic [WORD_SIZE-1:0]      REQ_DATA,
  output logic                      CE,
  output logic                      WE,
  output logic [ADDR_BIT_COUNT-1:0] ADDR,
  output logic [WORD_SIZE-1:0]      DIN,
  input  logic [WORD_SIZE-1:0]      DOUT,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [WORD_SIZE-1:0]      RSP_DATA
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

  // Handshake: a request transfers on a rising edge where REQ_VALID and REQ_READY
  // are both high; a response transfers where RSP_VALID and RSP_READY are both high.
  logic [CNT_W-1:0]     r_inflight;
  logic [CNT_W-1:0]     r_count;
  logic [RD_LAT-1:0]    r_pipe;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [WORD_SIZE-1:0] r_mem [RSP_DEPTH];

  logic [CNT_W:0] w_occ;
  logic           w_hs;
  logic           w_rd_hs;
  logic           w_capture;
  logic           w_full;
  logic           w_push;
  logic           w_pop;

  // Reserving a FIFO slot per in-flight read means a capture always finds room.
  assign w_occ     = {1'b0, r_inflight} + {1'b0, r_count};
  assign REQ_READY = RSTN && (w_occ < DEPTH_SUM);
  assign w_hs      = REQ_VALID & REQ_READY;
  assign w_rd_hs   = w_hs & ~REQ_WE;

  assign CE   = w_hs;
  assign WE   = w_hs & REQ_WE;
  assign ADDR = w_hs ? REQ_ADDR : '0;
  assign DIN  = (w_hs & REQ_WE) ? REQ_DATA : '0;

  assign w_capture = r_pipe[RD_LAT-1];
  assign w_full    = (r_count == DEPTH_CNT);
  assign w_push    = w_capture & ~w_full;
  assign RSP_VALID = (r_count != '0);
  assign w_pop     = RSP_VALID & RSP_READY;
  assign RSP_DATA  = RSP_VALID ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_rd_hs;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_inflight <= '0;
    end else begin
      case ({w_rd_hs, w_capture})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= DOUT;
  end

  // A capture into a full FIFO means the slot reservation was broken.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN) !(w_capture && w_full));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: RD_LAT=1 and RD_LAT=2 instances behind a shared
// driver, a behavioural memory, and an expected-response queue.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_ready;
  logic        streaming;

  logic        rr1, ce1, we1, rv1, rr2, ce2, we2, rv2;
  logic [10:0] addr1, addr2;
  logic [31:0] din1, din2, rd1, rd2, dout1, dout2;
  logic        v1, v2;

  logic        rr, ce, we, rv;
  logic [10:0] addr;
  logic [31:0] din, rd;

  logic [31:0] mem    [2048];
  logic [31:0] shadow [2048];
  logic [10:0] a1, a2_0, a2_1;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign v1 = req_valid & ~sel;
  assign v2 = req_valid & sel;

  mem_req_ctrl #(.ADDR_BIT_COUNT(11), .WORD_SIZE(32), .RD_LAT(1), .RSP_DEPTH(4)) u_dut1 (
    .CLK(clk), .RSTN(rst_n), .REQ_VALID(v1), .REQ_READY(rr1), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_DATA(req_data), .CE(ce1), .WE(we1), .ADDR(addr1),
    .DIN(din1), .DOUT(dout1), .RSP_VALID(rv1), .RSP_READY(rsp_ready), .RSP_DATA(rd1)
  );

  mem_req_ctrl #(.ADDR_BIT_COUNT(11), .WORD_SIZE(32), .RD_LAT(2), .RSP_DEPTH(4)) u_dut2 (
    .CLK(clk), .RSTN(rst_n), .REQ_VALID(v2), .REQ_READY(rr2), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_DATA(req_data), .CE(ce2), .WE(we2), .ADDR(addr2),
    .DIN(din2), .DOUT(dout2), .RSP_VALID(rv2), .RSP_READY(rsp_ready), .RSP_DATA(rd2)
  );

  assign rr   = sel ? rr2   : rr1;
  assign ce   = sel ? ce2   : ce1;
  assign we   = sel ? we2   : we1;
  assign addr = sel ? addr2 : addr1;
  assign din  = sel ? din2  : din1;
  assign rv   = sel ? rv2   : rv1;
  assign rd   = sel ? rd2   : rd1;

  // Behavioural memory: one read port per instance with that instance's latency.
  always @(posedge clk) begin
    if (ce1 && we1) mem[addr1] <= din1;
    if (ce2 && we2) mem[addr2] <= din2;
    a1   <= addr1;
    a2_0 <= addr2;
    a2_1 <= a2_0;
  end
  assign dout1 = mem[a1];
  assign dout2 = mem[a2_1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Response scoreboard: head must match whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'b0, rv}, 32'd0);
        end else begin
          chk("rsp_data", rd, exp_q[0]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (streaming) chk("stream_count_le2", {31'b0, (u_dut2.r_count <= 3'd2)}, 32'd1);
    end
  end

  task automatic run_ops(input int n, input logic w, input logic [10:0] base,
                         input int max_cyc, input bit toggle, output int acc);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < max_cyc) begin
      req_valid = 1'b1;
      req_we    = w;
      req_addr  = base + idx[10:0];
      req_data  = 32'h5EED0000 ^ {21'b0, base} ^ (idx * 32'h00010003);
      if (toggle) rsp_ready = ~rsp_ready;
      @(negedge clk);
      if (rr) begin
        chk("hs_ce", {31'b0, ce}, 32'd1);
        chk("hs_we", {31'b0, we}, {31'b0, w});
        chk("hs_addr", {21'b0, addr}, {21'b0, req_addr});
        chk("hs_din", din, w ? req_data : 32'd0);
        if (w) shadow[req_addr] = req_data;
        else   exp_q.push_back(shadow[req_addr]);
        idx++;
      end else begin
        chk("idle_ce", {31'b0, ce}, 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    acc = idx;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int i = 0; i < 2048; i++) begin
      mem[i]    = 32'hC0DE0000 ^ (i * 32'h01010101);
      shadow[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
    end
    sel = 1'b0; streaming = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h7FF; req_data = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, rr1}, 32'd0);
    chk("rst_ce", {31'b0, ce1}, 32'd0);
    chk("rst_we", {31'b0, we1}, 32'd0);
    chk("rst_addr", {21'b0, addr1}, 32'd0);
    chk("rst_din", din1, 32'd0);
    chk("rst_rsp_valid", {31'b0, rv1}, 32'd0);
    chk("rst_rsp_data", rd1, 32'd0);
    chk("rst_req_ready2", {31'b0, rr2}, 32'd0);
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'b0, rr}, 32'd1);

    // Single write then read back, RD_LAT=1.
    run_ops(1, 1'b1, 11'h123, 4, 1'b0, acc);
    req_data = 32'h5A5A1234;
    chk("wr_accepted", acc, 32'd1);
    shadow[11'h123] = 32'h5A5A1234;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h123; req_data = 32'h5A5A1234;
    @(negedge clk);
    chk("wr2_we", {31'b0, we}, 32'd1);
    chk("wr2_din", din, 32'h5A5A1234);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    run_ops(1, 1'b0, 11'h123, 4, 1'b0, acc);
    chk("rd_accepted", acc, 32'd1);
    @(negedge clk);
    chk("lat_before", {31'b0, rv}, 32'd0);
    @(negedge clk);
    chk("lat_at_hs_plus1", {31'b0, rv}, 32'd1);
    chk("lat_data", rd, 32'h5A5A1234);
    wait_drain("drain_single", 10);

    // Backpressure: only four reads fit.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run_ops(6, 1'b0, 11'h040, 10, 1'b0, acc);
    chk("bp_accepted", acc, 32'd4);
    @(negedge clk);
    chk("bp_ready_low", {31'b0, rr}, 32'd0);
    chk("bp_head", rd, shadow[11'h040]);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    run_ops(2, 1'b0, 11'h044, 20, 1'b0, acc);
    chk("drain_remaining", acc, 32'd2);
    wait_drain("drain_bp", 20);

    // Wrap-around with RSP_READY toggling every cycle.
    rsp_ready = 1'b0;
    run_ops(9, 1'b0, 11'h100, 40, 1'b1, acc);
    chk("wrap_accepted", acc, 32'd9);
    rsp_ready = 1'b1;
    wait_drain("drain_wrap", 20);

    // Streaming on the RD_LAT=2 instance.
    sel = 1'b1;
    @(posedge clk); #1;
    streaming = 1'b1;
    run_ops(20, 1'b0, 11'h200, 20, 1'b0, acc);
    chk("stream_accepted", acc, 32'd20);
    wait_drain("drain_stream", 10);
    streaming = 1'b0;

    // Reset with two reads in flight and one buffered.
    rsp_ready = 1'b0;
    run_ops(3, 1'b0, 11'h300, 3, 1'b0, acc);
    chk("mid_accepted", acc, 32'd3);
    req_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", {31'b0, rv}, 32'd0);
    chk("mid_req_ready", {31'b0, rr}, 32'd0);
    chk("mid_ce", {31'b0, ce}, 32'd0);
    exp_q.delete();
    req_valid = 1'b0;
    #3 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_stale", {31'b0, rv}, 32'd0);
    run_ops(1, 1'b0, 11'h301, 4, 1'b0, acc);
    chk("post_rst_accepted", acc, 32'd1);
    wait_drain("drain_post_rst", 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
